// File: rtl/alu_pipe_pkg.sv
// Shared definitions for the pipelined ALU: opcode encoding and status-flag layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pipe_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_CLR = 3'b111
  } alu_op_e;

  // Status flags travel together from the compute stage to the output register.
  typedef struct packed {
    logic carry;
    logic zero;
    logic ovf;
  } alu_flags_t;

  localparam int FLAGS_W = $bits(alu_flags_t);

endpackage

// File: rtl/alu_pipe_core.sv
// Combinational ALU: op, A, B -> result and carry/zero/ovf flags, modulo 2^WIDTH.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the result is captured.
// Ports: op_i opcode, a_i/b_i operands, result_o result, flags_o status flags.
module alu_pipe_core
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  alu_op_e          op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output alu_flags_t       flags_o
);

  // One extra bit catches the carry-out of ADD and the borrow of SUB.
  logic [WIDTH:0] sum_w;
  logic [WIDTH:0] diff_w;

  always_comb begin
    sum_w    = {1'b0, a_i} + {1'b0, b_i};
    diff_w   = {1'b0, a_i} - {1'b0, b_i};
    result_o = '0;
    flags_o  = '0;
    case (op_i)
      OP_ADD: begin
        result_o      = sum_w[WIDTH-1:0];
        flags_o.carry = sum_w[WIDTH];
        // Signed overflow: like-signed operands produce a differently-signed sum.
        flags_o.ovf   = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum_w[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SUB: begin
        result_o      = diff_w[WIDTH-1:0];
        flags_o.carry = diff_w[WIDTH];
        // Signed overflow: unlike-signed operands and the difference flips sign from A.
        flags_o.ovf   = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff_w[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_AND: result_o = a_i & b_i;
      OP_OR:  result_o = a_i | b_i;
      OP_XOR: result_o = a_i ^ b_i;
      OP_SHL: begin
        result_o      = {a_i[WIDTH-2:0], 1'b0};
        flags_o.carry = a_i[WIDTH-1];
      end
      OP_SHR: begin
        result_o      = {1'b0, a_i[WIDTH-1:1]};
        flags_o.carry = a_i[0];
      end
      default: result_o = '0;
    endcase
    flags_o.zero = (result_o == '0);
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline with an accumulator that can replace operand A.
// Latency: accept-to-out_valid exactly 2 cycles when not stalled.
// Backpressure: holds up to 2 transactions while out_ready=0; in_ready falls when both stages are full.
// Ports: clk/rst (sync, active-high); in_valid/in_ready/a/b/op/acc_mode upstream;
//        out_valid/out_ready/result/carry/zero/ovf downstream.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 8  // legal 4..32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             acc_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             ovf
);

  // Stage 1: registered operands.
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  alu_op_e          s1_op_q, s1_op_d;
  logic             s1_acc_q, s1_acc_d;

  // Stage 2: registered result, plus the accumulator written alongside it.
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  alu_flags_t       flags_q, flags_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic             s2_advance;
  logic             accept;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] core_result;
  alu_flags_t       core_flags;

  assign s2_advance = !out_valid_q || out_ready;
  assign in_ready   = !s1_valid_q || s2_advance;
  assign accept     = in_valid && in_ready;

  // The accumulator is written at compute time, so a back-to-back acc_mode
  // transaction sitting in S1 already sees its predecessor's result.
  assign op_a = s1_acc_q ? acc_q : s1_a_q;

  alu_pipe_core #(.WIDTH(WIDTH)) u_core (
    .op_i     (s1_op_q),
    .a_i      (op_a),
    .b_i      (s1_b_q),
    .result_o (core_result),
    .flags_o  (core_flags)
  );

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_op_d     = s1_op_q;
    s1_acc_d    = s1_acc_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
    acc_d       = acc_q;

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_a_d     = a;
      s1_b_d     = b;
      s1_op_d    = alu_op_e'(op);
      s1_acc_d   = acc_mode;
    end else if (s2_advance) begin
      s1_valid_d = 1'b0;
    end

    // S2 only changes when it may advance, so result/flags hold during a stall.
    if (s2_advance) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        result_d = core_result;
        flags_d  = core_flags;
        acc_d    = core_result;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_op_q     <= OP_ADD;
      s1_acc_q    <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      acc_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_op_q     <= s1_op_d;
      s1_acc_q    <= s1_acc_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      acc_q       <= acc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry     = flags_q.carry;
  assign zero      = flags_q.zero;
  assign ovf       = flags_q.ovf;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=8): vector table, directed corner sequences,
// and a random stream against a reference model, all scored through an expected-result queue.
// Inputs change 1ns after the rising edge; outputs and in_ready are sampled on the falling edge.
module tb_alu_pipe;

  typedef struct {
    logic [7:0] res;
    logic       c;
    logic       z;
    logic       v;
  } exp_t;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    exp_t       e;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] op;
  logic       acc_mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       carry;
  logic       zero;
  logic       ovf;

  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  int   n_out = 0;
  int   out_cycs[$];
  exp_t sb[$];
  exp_t me;
  logic [7:0] m_acc = 8'h00;
  bit   rnd_done = 1'b0;
  vec_t tbl[13];

  alu_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .acc_mode  (acc_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .zero      (zero),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference ALU evaluated with integer arithmetic.
  function automatic exp_t ref_alu(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    int ux = int'(x);
    int uy = int'(y);
    int sx = int'($signed(x));
    int sy = int'($signed(y));
    int r = 0;
    int s = 0;
    e.c = 1'b0;
    e.v = 1'b0;
    case (o)
      3'd0: begin r = ux + uy; e.c = (r > 255); s = sx + sy; e.v = (s > 127) || (s < -128); end
      3'd1: begin r = ux - uy; e.c = (ux < uy); s = sx - sy; e.v = (s > 127) || (s < -128); end
      3'd2: r = ux & uy;
      3'd3: r = ux | uy;
      3'd4: r = ux ^ uy;
      3'd5: begin r = ux * 2; e.c = (ux >= 128); end
      3'd6: begin r = ux / 2; e.c = (ux % 2 == 1); end
      default: r = 0;
    endcase
    e.res = r[7:0];
    e.z   = (e.res == 8'h00);
    return e;
  endfunction

  // Present one transaction, wait (bounded) for the handshake, push its expectation.
  task automatic send(input logic [2:0] o, input logic [7:0] ia, input logic [7:0] ib,
                      input logic am, input exp_t ex, input bit use_model);
    exp_t e;
    e = ex;
    in_valid = 1'b1; op = o; a = ia; b = ib; acc_mode = am;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (in_ready) begin
        if (use_model) e = ref_alu(o, am ? m_acc : ia, ib);
        sb.push_back(e);
        m_acc = e.res;
        break;
      end
      if (n >= 100) begin
        n_total++;
        $display("FAIL accept_timeout: in_ready stayed 0, expected 1 within 100 cycles");
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int n = 0; n < 50 && sb.size() != 0; n++) begin
      @(posedge clk); #1;
    end
    check("drain_pending", sb.size(), 0);
  endtask

  // Output scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL spurious_output: out_valid=1 result=0x%0h, expected no output", result);
      end else begin
        me = sb.pop_front();
        check("sb_result", result, me.res);
        check("sb_flags", {carry, zero, ovf}, {me.c, me.z, me.v});
        out_cycs.push_back(cyc);
        n_out++;
      end
    end
  end

  initial begin
    int base;
    exp_t e0;
    //          op     a      b       res    c     z     v
    tbl[0]  = '{3'd0, 8'hF0, 8'h20, '{8'h10, 1'b1, 1'b0, 1'b0}};
    tbl[1]  = '{3'd1, 8'h80, 8'h01, '{8'h7F, 1'b0, 1'b0, 1'b1}};
    tbl[2]  = '{3'd1, 8'h05, 8'h05, '{8'h00, 1'b0, 1'b1, 1'b0}};
    tbl[3]  = '{3'd2, 8'hCC, 8'hAA, '{8'h88, 1'b0, 1'b0, 1'b0}};
    tbl[4]  = '{3'd3, 8'h0C, 8'h30, '{8'h3C, 1'b0, 1'b0, 1'b0}};
    tbl[5]  = '{3'd4, 8'hFF, 8'hFF, '{8'h00, 1'b0, 1'b1, 1'b0}};
    tbl[6]  = '{3'd5, 8'h81, 8'h00, '{8'h02, 1'b1, 1'b0, 1'b0}};
    tbl[7]  = '{3'd6, 8'h81, 8'h00, '{8'h40, 1'b1, 1'b0, 1'b0}};
    tbl[8]  = '{3'd7, 8'h55, 8'hAA, '{8'h00, 1'b0, 1'b1, 1'b0}};
    tbl[9]  = '{3'd0, 8'h7F, 8'h01, '{8'h80, 1'b0, 1'b0, 1'b1}};
    tbl[10] = '{3'd1, 8'h00, 8'h01, '{8'hFF, 1'b1, 1'b0, 1'b0}};
    tbl[11] = '{3'd0, 8'hFF, 8'h01, '{8'h00, 1'b1, 1'b1, 1'b0}};
    tbl[12] = '{3'd6, 8'h01, 8'h00, '{8'h00, 1'b1, 1'b1, 1'b0}};

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0; acc_mode = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_result", result, 0);
    check("rst_flags", {carry, zero, ovf}, 0);
    check("rst_acc", dut.acc_q, 0);
    @(posedge clk); #1;

    // Latency: out_valid absent one cycle after accept, present two cycles after.
    send(tbl[0].op, tbl[0].a, tbl[0].b, 1'b0, tbl[0].e, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_cycle1_out_valid", out_valid, 0);
    @(negedge clk);
    check("lat_cycle2_out_valid", out_valid, 1);
    @(posedge clk); #1;

    // Vector table, back-to-back.
    for (int i = 0; i < 13; i++) send(tbl[i].op, tbl[i].a, tbl[i].b, 1'b0, tbl[i].e, 1'b0);
    in_valid = 1'b0;
    drain();

    // CLR then three accumulating ADDs: 00, 03, 06, 09 on consecutive cycles.
    out_cycs.delete();
    send(3'd7, 8'h5A, 8'h00, 1'b0, '{8'h00, 1'b0, 1'b1, 1'b0}, 1'b0);
    send(3'd0, 8'hEE, 8'h03, 1'b1, '{8'h03, 1'b0, 1'b0, 1'b0}, 1'b0);
    send(3'd0, 8'hEE, 8'h03, 1'b1, '{8'h06, 1'b0, 1'b0, 1'b0}, 1'b0);
    send(3'd0, 8'hEE, 8'h03, 1'b1, '{8'h09, 1'b0, 1'b0, 1'b0}, 1'b0);
    in_valid = 1'b0;
    drain();
    check("acc_out_count", out_cycs.size(), 4);
    for (int i = 0; i < 3 && i + 1 < out_cycs.size(); i++)
      check("acc_out_spacing", out_cycs[i+1] - out_cycs[i], 1);

    // Backpressure: two held, in_ready low, result stable, then in-order release.
    base = n_out;
    out_ready = 1'b0;
    send(3'd0, 8'h10, 8'h01, 1'b0, '{8'h11, 1'b0, 1'b0, 1'b0}, 1'b0);
    send(3'd4, 8'hF0, 8'h0F, 1'b0, '{8'hFF, 1'b0, 1'b0, 1'b0}, 1'b0);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_result_stable", result, 8'h11);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(3'd1, 8'h03, 8'h05, 1'b0, '{8'hFE, 1'b1, 1'b0, 1'b0}, 1'b0);
    send(3'd5, 8'hC0, 8'h00, 1'b0, '{8'h80, 1'b1, 1'b0, 1'b0}, 1'b0);
    in_valid = 1'b0;
    drain();
    check("bp_delivered", n_out - base, 4);

    // Reset with two in flight: both discarded.
    out_ready = 1'b0;
    send(3'd0, 8'h01, 8'h01, 1'b0, '{8'h02, 1'b0, 1'b0, 1'b0}, 1'b0);
    send(3'd0, 8'h02, 8'h02, 1'b0, '{8'h04, 1'b0, 1'b0, 1'b0}, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    sb.delete();
    m_acc = 8'h00;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rr_out_valid", out_valid, 0);
    check("rr_in_ready", in_ready, 1);
    check("rr_acc", dut.acc_q, 0);
    base = n_out;
    out_ready = 1'b1;
    @(posedge clk); #1;
    e0 = '{8'h40, 1'b1, 1'b0, 1'b0};
    send(3'd6, 8'h81, 8'h00, 1'b0, e0, 1'b0);
    in_valid = 1'b0;
    drain();
    check("rr_delivered", n_out - base, 1);

    // Random stream against the reference model with random out_ready.
    base = n_out;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
          end
          send(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
               1'($urandom_range(0, 1)), e0, 1'b1);
        end
        in_valid = 1'b0;
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check("rnd_delivered", n_out - base, 1000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width (legal 4..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  upstream presents a transaction.
REQ-005 SHALL have port in_ready  output  1  block accepts the transaction this cycle.
REQ-006 SHALL have port a  input  WIDTH  operand A.
REQ-007 SHALL have port b  input  WIDTH  operand B.
REQ-008 SHALL have port op  input  3  opcode.
REQ-009 SHALL have port acc_mode  input  1  use the accumulator in place of A.
REQ-010 SHALL have port out_valid  output  1  result presented.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-012 SHALL have port result  output  WIDTH  ALU result.
REQ-013 SHALL have ports carry, zero, ovf  output  1 each  status flags of result.

Function
REQ-014 SHALL accept a transaction on a cycle with in_valid && in_ready; it SHALL hold no state for unaccepted input.
REQ-015 SHALL be a 2-stage pipeline: S1 registers a/b/op/acc_mode; the compute is on the S1->S2 transfer; S2 drives result/flags. Accept-to-out_valid latency SHALL be exactly 2 cycles with no stall.
REQ-016 S2 SHALL advance (load or empty) when !out_valid || out_ready; S1 SHALL transfer to S2 only when S2 advances.
REQ-017 in_ready SHALL be !s1_valid || s2_advance; combinational, with no dependency on in_valid.
REQ-018 Full throughput (1 transaction/cycle) SHALL hold while out_ready=1; with out_ready=0, at most 2 transactions SHALL be held and in_ready SHALL fall.
REQ-019 result/flags SHALL stay stable while out_valid && !out_ready.
REQ-020 Opcodes SHALL be: 000 ADD A+B; 001 SUB A-B; 010 AND; 011 OR; 100 XOR; 101 SHL A<<1; 110 SHR A>>1 (logical); 111 CLR (result 0).
REQ-021 Arithmetic SHALL be modulo 2^WIDTH. For ADD, carry = carry-out of the WIDTH-bit sum. For SUB, carry = borrow (A<B unsigned). For SHL, carry = A[WIDTH-1]. For SHR, carry = A[0]. For all other opcodes, carry = 0.
REQ-022 ovf SHALL be signed two's-complement overflow for ADD/SUB, and 0 for all other opcodes; zero SHALL be (result==0) for every op.
REQ-023 When acc_mode=1, operand A SHALL be the accumulator register in place of a.
REQ-024 The accumulator SHALL load the computed result on every S1->S2 transfer, regardless of acc_mode; CLR SHALL therefore zero it.
REQ-025 Back-to-back acc_mode transactions SHALL see the result of the immediately preceding transaction with no bubble, because the accumulator updates at compute time.

Reset
REQ-026 On rst, s1_valid, out_valid, result, carry, zero, ovf and the accumulator SHALL go to 0 on the next edge; in_ready SHALL be 1 in the first cycle after reset.
REQ-027 rst asserted mid-operation SHALL discard both in-flight transactions; no out_valid SHALL follow for them.
REQ-028 rst SHALL take priority over any simultaneous handshake.

Structure
REQ-029 Opcode constants and the flag field layout SHALL live in shared package alu_pipe_pkg.
REQ-030 The combinational compute (op, A, B -> result, flags) SHALL be sub-module alu_pipe_core, parametrised by WIDTH; alu_pipe holds the registers and the handshake.

Verification (WIDTH=8)
REQ-031 ADD a=0xF0 b=0x20, out_ready=1 -> out_valid 2 cycles after accept, result=0x10, carry=1, ovf=0, zero=0.
REQ-032 SUB a=0x80 b=0x01 -> result=0x7F, carry=0, ovf=1; SUB a=0x05 b=0x05 -> result=0x00, zero=1.
REQ-033 Sequence CLR, then ADD(acc_mode=1, b=3) x3 back-to-back -> results 0x00, 0x03, 0x06, 0x09 on consecutive cycles.
REQ-034 Stream 4 transactions; hold out_ready=0 for 3 cycles -> in_ready=0 once 2 are held; result stable; all 4 delivered in order once released.
REQ-035 Assert rst with 2 in flight -> out_valid=0 next cycle, accumulator=0, in_ready=1; next SHR a=0x81 -> result=0x40, carry=1.
REQ-036 Random a/b/op/acc_mode vs a reference model for 1000 transactions with random out_ready -> zero mismatches.
